// File: rtl/run_length_detector.sv
// run_length_detector
// Watches a W-bit symbol stream sampled on en and flags runs of RUN_LEN or
// more identical symbols. It also reports the current run symbol and length,
// the longest run seen and the number of qualifying runs. z can be a level
// or a single-cycle pulse per run. All outputs are registered.
module run_length_detector #(
    parameter int W       = 1,
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W-1:0]     din,
    input  logic             mode,
    input  logic             clr_stats,
    output logic             z,
    output logic [W-1:0]     run_sym,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] max_run,
    output logic [CNT_W-1:0] det_count
);

    localparam logic [CNT_W-1:0] LP_SAT = '1;
    localparam logic [CNT_W-1:0] LP_RUN = CNT_W'(RUN_LEN);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_COUNT = 2'd1,
        S_DET   = 2'd2
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_sym;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] r_det;
    logic             r_z;

    state_t           w_state_nxt;
    logic [W-1:0]     w_sym_nxt;
    logic [CNT_W-1:0] w_len_nxt;
    logic [CNT_W-1:0] w_max_nxt;
    logic [CNT_W-1:0] w_det_nxt;
    logic             w_evt;
    logic             w_z_nxt;

    // Next-state, run tracking, statistics and detection output.
    always_comb begin
        w_state_nxt = r_state;
        w_sym_nxt   = r_sym;
        w_len_nxt   = r_len;
        w_max_nxt   = r_max;
        w_det_nxt   = r_det;
        w_evt       = 1'b0;

        if (en) begin
            if (r_state == S_EMPTY || din != r_sym) begin
                // A new run starts; RUN_LEN >= 2 so it can never detect here.
                w_sym_nxt   = din;
                w_len_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
                w_state_nxt = S_COUNT;
            end else begin
                w_len_nxt = (r_len == LP_SAT) ? r_len : r_len + 1'b1;
                // Only the COUNT->DET transition is an event, so a saturated
                // length sitting at RUN_LEN cannot re-trigger.
                if (r_state == S_COUNT && w_len_nxt == LP_RUN) begin
                    w_evt       = 1'b1;
                    w_state_nxt = S_DET;
                end
            end
        end

        if (w_evt && r_det != LP_SAT) begin
            w_det_nxt = r_det + 1'b1;
        end
        if (w_len_nxt > r_max) begin
            w_max_nxt = w_len_nxt;
        end
        if (clr_stats) begin
            w_max_nxt = '0;
            w_det_nxt = '0;
        end

        // Level mode tracks the DET state; pulse mode marks only the event.
        w_z_nxt = mode ? w_evt : (w_state_nxt == S_DET);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_EMPTY;
            r_sym   <= '0;
            r_len   <= '0;
            r_max   <= '0;
            r_det   <= '0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sym   <= w_sym_nxt;
            r_len   <= w_len_nxt;
            r_max   <= w_max_nxt;
            r_det   <= w_det_nxt;
            r_z     <= w_z_nxt;
        end
    end

    assign z         = r_z;
    assign run_sym   = r_sym;
    assign run_len   = r_len;
    assign max_run   = r_max;
    assign det_count = r_det;

endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector. Two instances share the control inputs:
// A is W=4/CNT_W=8, B is W=1/CNT_W=3 (legacy width, small counters for
// saturation). Both are compared every cycle against an unbounded-integer
// run model, plus directed scenario checks.
module tb_run_length_detector;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] din_a;
    logic [0:0] din_b;
    logic       mode;
    logic       clr_stats;

    logic       a_z, b_z;
    logic [3:0] a_sym;
    logic [0:0] b_sym;
    logic [7:0] a_len, a_max, a_det;
    logic [2:0] b_len, b_max, b_det;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state, index 0 = A, 1 = B
    int m_started[2];
    int m_sym[2];
    int m_len[2];
    int m_max[2];
    int m_cnt[2];
    int m_z[2];
    int m_sat[2];

    run_length_detector #(.W(4), .RUN_LEN(4), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .en(en), .din(din_a), .mode(mode),
        .clr_stats(clr_stats), .z(a_z), .run_sym(a_sym), .run_len(a_len),
        .max_run(a_max), .det_count(a_det)
    );

    run_length_detector #(.W(1), .RUN_LEN(4), .CNT_W(3)) u_b (
        .clk(clk), .rst(rst), .en(en), .din(din_b), .mode(mode),
        .clr_stats(clr_stats), .z(b_z), .run_sym(b_sym), .run_len(b_len),
        .max_run(b_max), .det_count(b_det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_upd(input int k, input bit r, input bit e,
                             input int d, input bit m, input bit c);
        bit evt;
        int l;
        if (!r) begin
            m_started[k] = 0; m_sym[k] = 0; m_len[k] = 0;
            m_max[k] = 0; m_cnt[k] = 0; m_z[k] = 0;
        end else begin
            evt = 1'b0;
            if (e) begin
                if (m_started[k] == 0 || d != m_sym[k]) begin
                    m_started[k] = 1;
                    m_sym[k] = d;
                    m_len[k] = 1;
                end else begin
                    m_len[k]++;
                    if (m_len[k] == 4) evt = 1'b1;
                end
            end
            if (evt) m_cnt[k]++;
            l = sat(m_len[k], m_sat[k]);
            if (l > m_max[k]) m_max[k] = l;
            if (c) begin
                m_max[k] = 0;
                m_cnt[k] = 0;
            end
            m_z[k] = m ? int'(evt) : int'(m_started[k] != 0 && m_len[k] >= 4);
        end
    endtask

    task automatic compare_all();
        check("a_z",   int'(a_z),   m_z[0]);
        check("a_sym", int'(a_sym), m_sym[0]);
        check("a_len", int'(a_len), sat(m_len[0], m_sat[0]));
        check("a_max", int'(a_max), m_max[0]);
        check("a_det", int'(a_det), sat(m_cnt[0], m_sat[0]));
        check("b_z",   int'(b_z),   m_z[1]);
        check("b_sym", int'(b_sym), m_sym[1]);
        check("b_len", int'(b_len), sat(m_len[1], m_sat[1]));
        check("b_max", int'(b_max), m_max[1]);
        check("b_det", int'(b_det), sat(m_cnt[1], m_sat[1]));
    endtask

    // one clock: drive at negedge, model at posedge, sample 1 time unit later
    task automatic step(input bit r, input bit e, input logic [3:0] d,
                        input bit m, input bit c);
        @(negedge clk);
        rst = r; en = e; din_a = d; din_b = d[0]; mode = m; clr_stats = c;
        @(posedge clk);
        model_upd(0, r, e, int'(d), m, c);
        model_upd(1, r, e, int'(d[0]), m, c);
        #1;
        compare_all();
    endtask

    initial begin
        m_sat[0] = 255;
        m_sat[1] = 7;
        rst = 1'b0; en = 1'b0; din_a = '0; din_b = '0; mode = 1'b0; clr_stats = 1'b0;

        // reset state
        step(0, 1, 4'h1, 0, 0);
        step(0, 0, 4'h0, 0, 0);
        check("rst_z", int'(a_z), 0);
        check("rst_len", int'(b_len), 0);

        // legacy behaviour: 1,1,1,1,1,0 in level mode
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 4'h1, 0, 0);
            check("t1_z", int'(b_z), (i >= 3) ? 1 : 0);
        end
        step(1, 1, 4'h0, 0, 0);
        check("t1_zfall", int'(b_z), 0);
        check("t1_len", int'(b_len), 1);
        check("t1_sym", int'(b_sym), 0);
        check("t1_det", int'(b_det), 1);
        check("t1_max", int'(b_max), 5);

        // pulse mode: 0xA x6 then 0x3 x4
        step(1, 0, 4'h0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 4'hA, 1, 0);
            check("t2_pa", int'(a_z), (i == 3) ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 4'h3, 1, 0);
            check("t2_pb", int'(a_z), (i == 3) ? 1 : 0);
        end
        check("t2_det", int'(a_det), 2);
        check("t2_max", int'(a_max), 6);

        // en gating in pulse mode: 0x5 on en=1 cycles, 0xF on en=0 cycles
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) step(1, 1, 4'h5, 1, 0);
            else            step(1, 0, 4'hF, 1, 0);
            check("t3_z", int'(a_z), (i == 6) ? 1 : 0);
        end
        check("t3_len", int'(a_len), 4);

        // saturation on the 3-bit counters
        step(0, 0, 4'h0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 4'h1, 0, 0);
        check("t4_len", int'(b_len), 7);
        check("t4_max", int'(b_max), 7);
        check("t4_det", int'(b_det), 1);

        // clear on the detect edge
        step(0, 0, 4'h0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 4'h6, 0, 0);
        step(1, 1, 4'h6, 0, 1);
        check("t5_det", int'(a_det), 0);
        check("t5_max", int'(a_max), 0);
        check("t5_z", int'(a_z), 1);
        step(1, 1, 4'h6, 0, 0);
        check("t5_len", int'(a_len), 5);

        // reset with clear mid-run in DET
        step(0, 1, 4'h6, 0, 1);
        check("t6_z", int'(a_z), 0);
        check("t6_len", int'(a_len), 0);
        check("t6_sym", int'(a_sym), 0);
        step(1, 1, 4'h6, 0, 0);
        check("t6_restart", int'(a_len), 1);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bit r, e, m, c;
            logic [3:0] d;
            r = ($urandom_range(0, 199) != 0);
            e = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 63) == 0) ? ~mode : mode;
            c = ($urandom_range(0, 49) == 0);
            d = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(0, 1));
            step(r, e, d, m, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
